// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM state, floor width and floor type for the elevator blocks
package elevator_pkg;
    localparam int N_FLOORS_DEFAULT = 3;
    localparam int FLOOR_W = 2;
    typedef logic [FLOOR_W-1:0] floor_t;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR, HALT} state_t;
endpackage

// File: rtl/door_timer.sv
// door_timer: door-open interval counter.
// Ports: i_clk/i_reset clock and sync reset; i_load (re)loads CYCLES;
// i_dec counts down toward zero; o_expired flags the final open cycle.
module door_timer #(
    parameter int CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);
    localparam int CW = $clog2(CYCLES + 1);
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= '0;
        else if (i_load)
            r_count <= CW'(CYCLES);
        else if (i_dec && r_count != '0)
            r_count <= r_count - 1'b1;
    end
    assign o_expired = r_count == CW'(1);
endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: SCAN call scheduler and car sequencer for the elevator.
// Ports: i_clk/i_reset clock and sync reset; i_call_req per-floor calls;
// i_step_done one-floor step finished; i_sos_mode halt; i_weight_limit_exceeded
// overload hold; o_call_pending latched calls; o_floor_pos current floor;
// o_move_up/o_move_down step commands; o_door_open door command; o_halted in HALT.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = N_FLOORS_DEFAULT,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_FLOORS-1:0] i_call_req,
    input  logic                i_step_done,
    input  logic                i_sos_mode,
    input  logic                i_weight_limit_exceeded,
    output logic [N_FLOORS-1:0] o_call_pending,
    output floor_t              o_floor_pos,
    output logic                o_move_up,
    output logic                o_move_down,
    output logic                o_door_open,
    output logic                o_halted
);
    state_t              r_state;
    floor_t              r_floor;
    logic                r_dir;
    logic [N_FLOORS-1:0] r_pending;
    logic                r_move_up, r_move_down, r_door_open, r_halted;
    logic [N_FLOORS-1:0] w_req, w_pend_in, w_floor_mask, w_nf_mask;
    floor_t              w_nf;
    logic                w_above, w_below, w_nf_above, w_nf_below;
    logic                w_here, w_ahead, w_behind, w_nf_ahead, w_new_dir;
    logic                w_reload, w_enter_door, w_expired;
    assign w_floor_mask = N_FLOORS'(1) << r_floor;
    assign w_nf_mask    = N_FLOORS'(1) << w_nf;
    // Calls are dropped in HALT; a same-floor call during DOOR only holds the door.
    assign w_req     = (r_state == HALT) ? '0
                     : i_call_req & ~((r_state == DOOR) ? w_floor_mask : '0);
    assign w_pend_in = r_pending | w_req;
    assign w_nf = r_dir ? ((r_floor == floor_t'(N_FLOORS - 1)) ? r_floor : r_floor + 1'b1)
                        : ((r_floor == '0) ? r_floor : r_floor - 1'b1);
    always_comb begin
        w_above    = 1'b0;
        w_below    = 1'b0;
        w_nf_above = 1'b0;
        w_nf_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (floor_t'(i) > r_floor) w_above = w_above | r_pending[i];
            if (floor_t'(i) < r_floor) w_below = w_below | r_pending[i];
            if (floor_t'(i) > w_nf) w_nf_above = w_nf_above | w_pend_in[i];
            if (floor_t'(i) < w_nf) w_nf_below = w_nf_below | w_pend_in[i];
        end
    end
    assign w_here     = r_pending[r_floor];
    assign w_ahead    = r_dir ? w_above : w_below;
    assign w_behind   = r_dir ? w_below : w_above;
    assign w_nf_ahead = r_dir ? w_nf_above : w_nf_below;
    assign w_new_dir  = w_ahead ? r_dir : ~r_dir;
    assign w_reload   = i_weight_limit_exceeded || i_call_req[r_floor];
    // A call landing with step_done at the arrival floor counts as pending.
    assign w_enter_door = !i_sos_mode &&
        ((r_state == IDLE && w_here) ||
         (r_state == MOVE && i_step_done && w_pend_in[w_nf]));
    door_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_enter_door || (r_state == DOOR && w_reload)),
        .i_dec     (r_state == DOOR),
        .o_expired (w_expired)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_floor     <= '0;
            r_dir       <= 1'b1;
            r_pending   <= '0;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b0;
            r_door_open <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_pending <= w_pend_in;
            case (r_state)
                IDLE: begin
                    if (i_sos_mode) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_here) begin
                        r_state     <= DOOR;
                        r_pending   <= w_pend_in & ~w_floor_mask;
                        r_door_open <= 1'b1;
                    end else if (!i_weight_limit_exceeded && (w_ahead || w_behind)) begin
                        r_state     <= MOVE;
                        r_dir       <= w_new_dir;
                        r_move_up   <= w_new_dir;
                        r_move_down <= ~w_new_dir;
                    end
                end
                MOVE: begin
                    if (i_step_done) begin
                        r_floor <= w_nf;
                        if (i_sos_mode) begin
                            r_state     <= HALT;
                            r_move_up   <= 1'b0;
                            r_move_down <= 1'b0;
                            r_halted    <= 1'b1;
                        end else if (w_pend_in[w_nf]) begin
                            r_state     <= DOOR;
                            r_pending   <= w_pend_in & ~w_nf_mask;
                            r_move_up   <= 1'b0;
                            r_move_down <= 1'b0;
                            r_door_open <= 1'b1;
                        end else if (!w_nf_ahead) begin
                            r_state     <= IDLE;
                            r_move_up   <= 1'b0;
                            r_move_down <= 1'b0;
                        end
                    end
                end
                DOOR: begin
                    if (i_sos_mode) begin
                        r_state     <= HALT;
                        r_door_open <= 1'b0;
                        r_halted    <= 1'b1;
                    end else if (w_expired && !w_reload) begin
                        r_state     <= IDLE;
                        r_door_open <= 1'b0;
                    end
                end
                HALT: begin
                    if (!i_sos_mode) begin
                        r_state  <= IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_call_pending = r_pending;
    assign o_floor_pos    = r_floor;
    assign o_move_up      = r_move_up;
    assign o_move_down    = r_move_down;
    assign o_door_open    = r_door_open;
    assign o_halted       = r_halted;
endmodule

// File: doc/call_scheduler.md
# call_scheduler

Call scheduler and car sequencer for the three-floor elevator. It latches floor calls, chooses the travel direction with a SCAN policy (keep going while calls lie ahead, otherwise reverse), and commands single-floor steps to the motion datapath. It times the door-open interval and obeys the emergency inputs: SOS halt and weight-limit hold. It sits between the push buttons and the car motion logic, and runs on the divided slow clock `clk`.

## Interface
- `N_FLOORS`, 3, number of floors; floors are numbered 0..N_FLOORS-1.
- `DOOR_CYCLES`, 3, number of `clk` cycles the door stays open (must be ≥1).
- `clk` input 1: the single clock. Every register updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `call_req` input N_FLOORS: per-floor call request. Sampled every cycle; level or pulse are both accepted.
- `step_done` input 1: one-cycle pulse from the motion datapath. The car has completed one floor step in the commanded direction.
- `sos_mode` input 1: emergency halt request (level).
- `weight_limit_exceeded` input 1: overload (level).
- `call_pending` output N_FLOORS: latched calls; drives the call LEDs.
- `floor_pos` output 2: current floor, binary.
- `move_up` output 1: step command, up (level).
- `move_down` output 1: step command, down (level).
- `door_open` output 1: door open command.
- `halted` output 1: high while in HALT.

## Operation
- States: IDLE, MOVE, DOOR, HALT.
- Internal `dir` register: 1 = up. Reset value 1.
- Reset values: state IDLE, `floor_pos` 0, `call_pending` 0, `dir` 1, all other outputs 0, door counter 0. Reset mid-operation reaches these values on the next edge. `step_done` is ignored while `reset` is high.
- Call latching: a `call_req[i]` sampled high sets `call_pending[i]` on the next edge. Exceptions:
  - the request is ignored in HALT;
  - a request for `floor_pos` while in DOOR is not latched; it reloads the door counter instead.
- Bits are cleared only when the door opens at that floor.
- "Ahead": a pending call at a floor above `floor_pos` when `dir`=1, or below it when `dir`=0.
- IDLE, evaluated in priority order:
  - `sos_mode` → HALT.
  - `call_pending[floor_pos]` → DOOR; clear that bit.
  - `weight_limit_exceeded` → stay in IDLE; no departure.
  - Calls ahead → MOVE in `dir`.
  - Calls only behind → invert `dir`, then MOVE.
  - No calls → stay in IDLE.
- MOVE:
  - `move_up` equals `dir` and `move_down` equals `~dir`; exactly one is high for the whole state.
  - On `step_done`, `floor_pos` ±1 (saturating at 0 and N_FLOORS-1).
  - Then: if `sos_mode`, go to HALT. Else if the new floor is pending, go to DOOR and clear the bit. Else if calls remain ahead, stay in MOVE. Else go to IDLE.
  - `sos_mode` never aborts a step in flight.
- DOOR:
  - `door_open`=1.
  - Counter loads `DOOR_CYCLES` on entry and decrements once per cycle.
  - The counter reloads whenever `weight_limit_exceeded` is high or a same-floor call arrives.
  - Exit to IDLE when the counter reaches 1 and no reload condition holds.
  - `sos_mode` → HALT immediately; the door command drops.
- HALT:
  - All motion outputs are 0, `door_open`=0, `halted`=1. `call_pending` is retained.
  - Leave to IDLE on the first cycle `sos_mode` is low.
- Simultaneous events:
  - SOS outranks a pending call, which outranks weight.
  - A call at the current floor arriving in the same cycle as `step_done` for that floor is treated as pending; the door opens.

## Timing
- All outputs are registered.
- Call to LED: `call_pending` is visible 1 cycle after `call_req`.
- Call to motion: from IDLE, `move_*` asserts 2 cycles after `call_req` (latch, then decide).
- Arrival: after `step_done`, `floor_pos` updates and `move_*` drops or `door_open` rises on the same next edge.
- Door: `door_open` is high for exactly `DOOR_CYCLES` cycles without reloads. A reload extends it to `DOOR_CYCLES` cycles after the last reload cycle.
- `move_up` and `move_down` are never high together, and never high while `door_open` is high.

## Structure
- Shared package `elevator_pkg` holds:
  - the state enum (IDLE, MOVE, DOOR, HALT);
  - `N_FLOORS_DEFAULT`;
  - `FLOOR_W` = 2;
  - the `floor_t` typedef.
- Sub-module `door_timer` contains the load/reload/decrement counter and the `expired` flag.
- Call latching and SCAN direction logic stay in `call_scheduler`.

## Test plan
- Reset, then `call_req`=3'b100 for one cycle:
  - `call_pending`=100 at cycle 1 and `move_up`=1 at cycle 2;
  - after two `step_done` pulses, `floor_pos`=2, `door_open` high for 3 cycles, and `call_pending`=000.
- At floor 1 with `dir`=1, calls latched at floors 0 and 2 in the same cycle: serve floor 2 first, then reverse and serve floor 0.
- Call at floor 0 while idle at floor 0: DOOR on the next decision cycle, no `move_*`. A repeat call during DOOR extends `door_open` to 3 cycles after the last request.
- `weight_limit_exceeded` held 5 cycles during DOOR: `door_open` stays high through those cycles plus 3. With overload high in IDLE and a call at another floor, no `move_*` until overload clears.
- `sos_mode` raised mid-MOVE: `move_*` held until `step_done`, then `halted`=1. Calls pressed during HALT are not latched; previously pending calls survive; normal service resumes when `sos_mode` falls.
- `reset` pulsed during DOOR at floor 2: next cycle `floor_pos`=0, `door_open`=0, `call_pending`=0, state IDLE.
